// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ifetch_pkg
// Purpose  : Shared state encoding and constants for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    ISSUE  = 3'd3,
    INJECT = 3'd4,
    HALT   = 3'd5
  } ifetch_state_t;

  localparam logic [15:0] INSTR_END = 16'h0000;
  localparam int          PC_STEP   = 2;
  localparam int          BR_BIAS   = 4;

endpackage
`default_nettype wire

// File: rtl/ifetch_perf_ctr.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_perf_ctr
// Purpose  : Pair of saturating 32-bit event counters (accepted instructions,
//            fetch/stall cycles). Present only when IFETCH_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef IFETCH_PERF_EN
module ifetch_perf_ctr
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_inc_instr,
  input  logic        i_inc_stall,
  output logic [31:0] o_perf_instr,
  output logic [31:0] o_perf_stall
);

  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  // Counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_inc_instr && (r_instr_cnt != '1)) begin
        r_instr_cnt <= r_instr_cnt + 32'd1;
      end
      if (i_inc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_perf_instr = r_instr_cnt;
  assign o_perf_stall = r_stall_cnt;

endmodule
`endif
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage ahead of controlunit: owns the PC, keeps one imem read
//            outstanding, issues instructions by handshake and applies branch,
//            self-instruct and end-program feedback. Optional IFETCH_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_rvalid_i,
  input  logic [15:0]       imem_rdata_i,
  output logic [15:0]       instr_o,
  output logic              instr_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [10:0]       branch_off_i,
  input  logic              self_instr_en_i,
  input  logic [15:0]       self_instr_i,
  input  logic              end_program_i,
  output logic              halted_o,
  output logic              fetch_err_o
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_instr_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  ifetch_state_t     r_state;
  ifetch_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_instr;
  logic [15:0]       w_instr_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_err;
  logic              w_err_nxt;

  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_br_target;
  logic              w_accept;

  // Halfword offset, sign-extended and scaled to bytes; target forced even.
  assign w_br_off    = {{(ADDR_W-12){branch_off_i[10]}}, branch_off_i, 1'b0};
  assign w_br_target = (r_pc + ADDR_W'(BR_BIAS) + w_br_off) & ~ADDR_W'(1);

  assign instr_valid_o = (r_state == ISSUE) || (r_state == INJECT);
  assign w_accept      = instr_valid_o && !stall_i;
  assign imem_req_o    = (r_state == REQ);
  assign imem_addr_o   = r_pc;
  assign instr_o       = r_instr;
  assign pc_o          = r_pc;
  assign halted_o      = (r_state == HALT);
  assign fetch_err_o   = r_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          w_instr_nxt = imem_rdata_i;
          w_state_nxt = ISSUE;
        end else if (r_cnt == CNT_W'(MAX_WAIT)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = HALT;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ISSUE, INJECT: begin
        // An injected instruction keeps its originator's PC, so the
        // sequential step after it completes the originator.
        if (w_accept) begin
          if (end_program_i || (r_instr == INSTR_END)) begin
            w_state_nxt = HALT;
          end else if (branch_i) begin
            w_pc_nxt    = w_br_target;
            w_state_nxt = REQ;
          end else if (self_instr_en_i) begin
            w_instr_nxt = self_instr_i;
            w_state_nxt = INJECT;
          end else begin
            w_pc_nxt    = r_pc + ADDR_W'(PC_STEP);
            w_state_nxt = REQ;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

`ifdef IFETCH_PERF_EN
  logic w_perf_stall_inc;

  assign w_perf_stall_inc = (r_state == REQ) || (r_state == WAIT) || (instr_valid_o && stall_i);

  ifetch_perf_ctr u_perf (
    .clk          (clk_i),
    .rst_n        (rst_n_i),
    .i_inc_instr  (w_accept),
    .i_inc_stall  (w_perf_stall_inc),
    .o_perf_instr (perf_instr_o),
    .o_perf_stall (perf_stall_o)
  );
`endif

endmodule
`default_nettype wire
